// File: rtl/security_bus_initiator_pkg.sv
// Shared definitions for the security bus initiator:
//   - default core address on the peripheral bus
//   - command codes of the key-check sequence
//   - FSM state encoding
//   - helpers that map the command index (0..3) to a bus command and its write data
package security_bus_initiator_pkg;

    localparam logic [15:0] SEG_CORE_ADDR = 16'h0016;

    localparam logic [3:0] CMD_NONE      = 4'd0;
    localparam logic [3:0] CMD_CLAVE_H   = 4'd1;
    localparam logic [3:0] CMD_CLAVE_L   = 4'd2;
    localparam logic [3:0] CMD_COINCIDEN = 4'd3;
    localparam logic [3:0] CMD_INFORMAR  = 4'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_GAP    = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    function automatic logic [3:0] cmd_code(input logic [1:0] idx);
        case (idx)
            2'd0:    cmd_code = CMD_CLAVE_H;
            2'd1:    cmd_code = CMD_CLAVE_L;
            2'd2:    cmd_code = CMD_COINCIDEN;
            default: cmd_code = CMD_INFORMAR;
        endcase
    endfunction

    // Only the two key-load commands carry write data.
    function automatic logic [15:0] cmd_data(input logic [31:0] key, input logic [1:0] idx);
        case (idx)
            2'd0:    cmd_data = key[31:16];
            2'd1:    cmd_data = key[15:0];
            default: cmd_data = 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/security_bus_initiator_if.sv
// Processor peripheral handshake bus between the initiator and the security core.
//   addr    16  bus address
//   data_o  16  write data towards the peripheral
//   en       1  bus enable
//   cmd      4  command code
//   isDone   1  peripheral completion flag
//   data_i  16  read data from the peripheral
// master: initiator side, slave: peripheral side.
interface security_bus_initiator_if;
    logic [15:0] addr;
    logic [15:0] data_o;
    logic        en;
    logic [3:0]  cmd;
    logic        isDone;
    logic [15:0] data_i;

    modport master (output addr, data_o, en, cmd, input isDone, data_i);
    modport slave  (input addr, data_o, en, cmd, output isDone, data_i);
endinterface

// File: rtl/security_bus_initiator_bus_watchdog.sv
// Per-command watchdog for the WAIT phase.
//   clk, reset  clock and async active-low reset
//   clear       reload the timer (one cycle before waiting starts)
//   enable      count down while waiting for isDone
//   expired     high on the TIMEOUT_CYCLES-th enabled cycle after clear
// Down-counter saturating at zero, so it can never wrap back to a live value.
module security_bus_initiator_bus_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Loading TIMEOUT_CYCLES-1 makes the terminal count coincide with the
    // TIMEOUT_CYCLES-th waiting cycle itself.
    localparam logic [15:0] LOAD = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= LOAD;
        end else if (enable && (count != 16'd0)) begin
            count <= count - 16'd1;
        end
    end

    assign expired = (count == 16'd0);

endmodule

// File: rtl/security_bus_initiator.sv
// Bus-master sequencer that runs the key check against the security core:
// CLAVE_H(key[31:16]) -> CLAVE_L(key[15:0]) -> COINCIDEN -> INFORMAR.
//   clk, reset   clock and async active-low reset
//   start, key_i request (accepted only in IDLE) and key captured with it
//   busy, done   sequence in flight / one-cycle end pulse
//   match        COINCIDEN result bit 0
//   status       INFORMAR result bits [2:0]
//   timeout_err  a command saw no isDone within TIMEOUT_CYCLES
//   bus          master side of the peripheral handshake
//
// state  | meaning
// IDLE   | waiting for start
// ISSUE  | first enabled cycle of a command; isDone ignored (may be stale)
// WAIT   | bus held stable until isDone or watchdog expiry
// GAP    | en low for GAP_CYCLES between commands
// FINISH | done pulse, bus fields cleared
module security_bus_initiator
    import security_bus_initiator_pkg::*;
#(
    parameter logic [15:0] CORE_ADDR      = SEG_CORE_ADDR,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned GAP_CYCLES     = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [31:0]                key_i,
    output logic                       busy,
    output logic                       done,
    output logic                       match,
    output logic [2:0]                 status,
    output logic                       timeout_err,
    security_bus_initiator_if.master   bus
);

    localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES - 1);

    state_t      state;
    logic [1:0]  idx;
    logic [1:0]  idx_next;
    logic [31:0] key_reg;
    logic [15:0] gap_cnt;
    logic        wd_expired;

    assign idx_next = idx + 2'd1;

    security_bus_initiator_bus_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == ST_ISSUE),
        .enable  (state == ST_WAIT),
        .expired (wd_expired)
    );

    // Outputs are registered: the bus fields for a command are loaded on the
    // edge that enters ISSUE, so en is high for the whole ISSUE cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            idx         <= 2'd0;
            key_reg     <= '0;
            gap_cnt     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            match       <= 1'b0;
            status      <= 3'd0;
            timeout_err <= 1'b0;
            bus.addr    <= '0;
            bus.data_o  <= '0;
            bus.en      <= 1'b0;
            bus.cmd     <= CMD_NONE;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        key_reg     <= key_i;
                        idx         <= 2'd0;
                        busy        <= 1'b1;
                        timeout_err <= 1'b0;
                        bus.en      <= 1'b1;
                        bus.addr    <= CORE_ADDR;
                        bus.cmd     <= cmd_code(2'd0);
                        bus.data_o  <= cmd_data(key_i, 2'd0);
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // isDone takes priority over a watchdog expiring in the same cycle.
                    if (bus.isDone) begin
                        if (idx == 2'd2) match  <= bus.data_i[0];
                        if (idx == 2'd3) status <= bus.data_i[2:0];
                        bus.en  <= 1'b0;
                        gap_cnt <= GAP_LOAD;
                        state   <= ST_GAP;
                    end else if (wd_expired) begin
                        timeout_err <= 1'b1;
                        bus.en      <= 1'b0;
                        bus.cmd     <= CMD_NONE;
                        bus.addr    <= '0;
                        bus.data_o  <= '0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= ST_FINISH;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt != 16'd0) begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end else if (idx == 2'd3) begin
                        bus.cmd    <= CMD_NONE;
                        bus.addr   <= '0;
                        bus.data_o <= '0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= ST_FINISH;
                    end else begin
                        idx        <= idx_next;
                        bus.en     <= 1'b1;
                        bus.addr   <= CORE_ADDR;
                        bus.cmd    <= cmd_code(idx_next);
                        bus.data_o <= cmd_data(key_reg, idx_next);
                        state      <= ST_ISSUE;
                    end
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
